// File: rtl/pong_pkg.sv
// Shared pong playfield geometry, paddle motion states and coordinate type.
// Consumed by the paddle, ball and display datapaths.
package pong_pkg;

    localparam int Y_WIDTH         = 10;
    localparam int TOP_BOUNDARY    = 3;
    localparam int BOTTOM_BOUNDARY = 477;
    localparam int LEFT_BOUNDARY   = 3;
    localparam int RIGHT_BOUNDARY  = 637;
    localparam int PADDLE_HEIGHT   = 46;
    localparam int PADDLE_WIDTH    = 7;
    localparam int BALL_SIZE       = 7;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } paddle_move_t;

    typedef logic [Y_WIDTH-1:0] coord_t;

endpackage

// File: rtl/paddle_ctrl_if.sv
// Paddle controller bundle: tick/recentre strobes, per-channel controls and ball Y in,
// flattened paddle positions and status flags out.
interface paddle_ctrl_if #(
    parameter int NUM_PADDLES = 2,
    parameter int Y_WIDTH     = 10
);
    logic                           tick;
    logic [NUM_PADDLES-1:0]         mode;
    logic [NUM_PADDLES-1:0]         btn_up;
    logic [NUM_PADDLES-1:0]         btn_down;
    logic [Y_WIDTH-1:0]             ball_y;
    logic                           recenter;
    logic [NUM_PADDLES*Y_WIDTH-1:0] paddle_y;
    logic [NUM_PADDLES-1:0]         at_limit;
    logic [NUM_PADDLES-1:0]         moving;

    modport master (
        output tick, mode, btn_up, btn_down, ball_y, recenter,
        input  paddle_y, at_limit, moving
    );

    modport slave (
        input  tick, mode, btn_up, btn_down, ball_y, recenter,
        output paddle_y, at_limit, moving
    );
endinterface

// File: rtl/button_debounce.sv
// One push-button: 2-flop synchroniser, inversion to active-high, and a tick-qualified
// stability counter. Debounced level changes after DEBOUNCE_TICKS agreeing ticks.
module button_debounce #(
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_n,
    output logic pressed
);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    logic [1:0]    sync_q, sync_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level;

    assign level   = ~sync_q[1];
    assign pressed = deb_q;

    always_comb begin
        sync_d = {sync_q[0], btn_n};
        deb_d  = deb_q;
        cnt_d  = cnt_q;
        if (tick) begin
            if (level != deb_q) begin
                if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                    deb_d = level;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Per-channel paddle position: player (debounced buttons) or AI (tracks ball), clamped
// to the playfield. New paddle_y one clk after tick; recenter overrides tick.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int NUM_PADDLES     = 2,
    parameter int Y_WIDTH         = pong_pkg::Y_WIDTH,
    parameter int TOP_BOUNDARY    = pong_pkg::TOP_BOUNDARY,
    parameter int BOTTOM_BOUNDARY = pong_pkg::BOTTOM_BOUNDARY,
    parameter int PADDLE_HEIGHT   = pong_pkg::PADDLE_HEIGHT,
    parameter int BALL_SIZE       = pong_pkg::BALL_SIZE,
    parameter int PLAYER_STEP     = 4,
    parameter int AI_STEP         = 3,
    parameter int AI_DEADBAND     = 4,
    parameter int DEBOUNCE_TICKS  = 3,
    parameter int RESET_Y         = 217
) (
    input  logic          clk,
    input  logic          reset,
    paddle_ctrl_if.slave  pif
);
    localparam int MIN_Y = TOP_BOUNDARY;
    localparam int MAX_Y = BOTTOM_BOUNDARY - PADDLE_HEIGHT;
    localparam int SW    = Y_WIDTH + 2;

    typedef logic signed [SW-1:0] sval_t;

    localparam sval_t MIN_S       = sval_t'(MIN_Y);
    localparam sval_t MAX_S       = sval_t'(MAX_Y);
    localparam sval_t HALF_BALL   = sval_t'(BALL_SIZE / 2);
    localparam sval_t HALF_PADDLE = sval_t'(PADDLE_HEIGHT / 2);
    localparam sval_t PLAYER_S    = sval_t'(PLAYER_STEP);
    localparam sval_t AI_S        = sval_t'(AI_STEP);
    localparam sval_t DEAD_S      = sval_t'(AI_DEADBAND);
    localparam sval_t NEG_DEAD_S  = sval_t'(-AI_DEADBAND);

    localparam logic [Y_WIDTH-1:0] MIN_C   = Y_WIDTH'(MIN_Y);
    localparam logic [Y_WIDTH-1:0] MAX_C   = Y_WIDTH'(MAX_Y);
    localparam logic [Y_WIDTH-1:0] RESET_C = Y_WIDTH'(RESET_Y);
    localparam logic RESET_AT_LIMIT = (RESET_Y == MIN_Y) || (RESET_Y == MAX_Y);

    if (RESET_Y < MIN_Y || RESET_Y > MAX_Y) begin : g_bad_reset_y
        $error("paddle_ctrl: RESET_Y outside [MIN_Y, MAX_Y]");
    end

    logic [NUM_PADDLES-1:0] up_pressed;
    logic [NUM_PADDLES-1:0] down_pressed;

    for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_chan
        button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_up (
            .clk     (clk),
            .reset   (reset),
            .tick    (pif.tick),
            .btn_n   (pif.btn_up[g]),
            .pressed (up_pressed[g])
        );

        button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_down (
            .clk     (clk),
            .reset   (reset),
            .tick    (pif.tick),
            .btn_n   (pif.btn_down[g]),
            .pressed (down_pressed[g])
        );

        paddle_move_t       state_q, state_d, move_sel;
        logic [Y_WIDTH-1:0] y_q, y_d;
        logic               moving_q, moving_d;
        logic               at_limit_q, at_limit_d;
        sval_t              aim, centre, err, err_abs, step, cur, y_move, y_clamped;

        always_comb begin
            cur     = $signed({2'b00, y_q});
            aim     = $signed({2'b00, pif.ball_y}) + HALF_BALL;
            centre  = cur + HALF_PADDLE;
            err     = aim - centre;
            err_abs = err[SW-1] ? -err : err;

            move_sel = HOLD;
            step     = PLAYER_S;
            if (pif.mode[g]) begin
                step = (err_abs < AI_S) ? err_abs : AI_S;
                if (err < NEG_DEAD_S) begin
                    move_sel = UP;
                end else if (err > DEAD_S) begin
                    move_sel = DOWN;
                end
            end else if (up_pressed[g] && !down_pressed[g]) begin
                move_sel = UP;
            end else if (down_pressed[g] && !up_pressed[g]) begin
                move_sel = DOWN;
            end

            // Screen Y grows downward, so UP subtracts.
            case (move_sel)
                UP:      y_move = cur - step;
                DOWN:    y_move = cur + step;
                default: y_move = cur;
            endcase

            if (y_move < MIN_S) begin
                y_clamped = MIN_S;
            end else if (y_move > MAX_S) begin
                y_clamped = MAX_S;
            end else begin
                y_clamped = y_move;
            end

            state_d    = state_q;
            y_d        = y_q;
            moving_d   = moving_q;
            at_limit_d = at_limit_q;
            if (pif.recenter) begin
                state_d    = HOLD;
                y_d        = RESET_C;
                moving_d   = 1'b0;
                at_limit_d = RESET_AT_LIMIT;
            end else if (pif.tick) begin
                state_d    = move_sel;
                y_d        = y_clamped[Y_WIDTH-1:0];
                moving_d   = (y_d != y_q);
                at_limit_d = (y_d == MIN_C) || (y_d == MAX_C);
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q    <= HOLD;
                y_q        <= RESET_C;
                moving_q   <= 1'b0;
                at_limit_q <= 1'b0;
            end else begin
                state_q    <= state_d;
                y_q        <= y_d;
                moving_q   <= moving_d;
                at_limit_q <= at_limit_d;
            end
        end

        assign pif.paddle_y[g*Y_WIDTH +: Y_WIDTH] = y_q;
        assign pif.at_limit[g]                    = at_limit_q;
        assign pif.moving[g]                      = moving_q;
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: debounce, player motion and clamping, AI tracking
// with deadband, recentre priority and asynchronous reset.
module tb_paddle_ctrl;
    import pong_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   exp_y;
    int   nxt_y;

    always #5 clk = ~clk;

    paddle_ctrl_if #(.NUM_PADDLES(2), .Y_WIDTH(10)) pif ();

    paddle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .pif   (pif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] y0();
        return 32'(pif.paddle_y[9:0]);
    endfunction

    function automatic logic [31:0] y1();
        return 32'(pif.paddle_y[19:10]);
    endfunction

    task automatic do_tick();
        @(negedge clk);
        pif.tick = 1'b1;
        @(negedge clk);
        pif.tick = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pif.tick     = 1'b0;
        pif.mode     = 2'b00;
        pif.btn_up   = 2'b11;
        pif.btn_down = 2'b11;
        pif.ball_y   = 10'd0;
        pif.recenter = 1'b0;
        reset        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_y0", y0(), 217);
        chk("rst_y1", y1(), 217);
        chk("rst_lim", 32'(pif.at_limit), 0);
        chk("rst_mov", 32'(pif.moving), 0);
        reset = 1'b1;
        settle();

        // Player down on channel 0: three ticks to debounce, then +4 per tick.
        pif.btn_down[0] = 1'b0;
        settle();
        repeat (3) begin
            do_tick();
            chk("deb_wait_y0", y0(), 217);
        end
        do_tick();
        chk("first_step_y0", y0(), 221);
        chk("first_step_mov", 32'(pif.moving[0]), 1);
        repeat (20) do_tick();
        chk("mid_move_y0", y0(), 301);

        // Asynchronous reset while moving.
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_rst_y0", y0(), 217);
        chk("async_rst_lim", 32'(pif.at_limit), 0);
        chk("async_rst_mov", 32'(pif.moving), 0);
        @(negedge clk);
        reset = 1'b1;
        settle();

        repeat (3) begin
            do_tick();
            chk("deb_wait2_y0", y0(), 217);
        end
        exp_y = 217;
        for (int i = 0; i < 60; i++) begin
            do_tick();
            nxt_y = (exp_y + 4 > 431) ? 431 : exp_y + 4;
            chk("down_run_y0", y0(), 32'(nxt_y));
            chk("down_run_mov", 32'(pif.moving[0]), (nxt_y != exp_y) ? 1 : 0);
            exp_y = nxt_y;
        end
        chk("bottom_lim", 32'(pif.at_limit[0]), 1);
        chk("bottom_mov", 32'(pif.moving[0]), 0);
        chk("idle_ch1_y1", y1(), 217);

        // Both pressed: hold; a 2-tick release glitch on up must not register.
        pif.btn_up[0] = 1'b0;
        settle();
        repeat (3) do_tick();
        repeat (10) begin
            do_tick();
            chk("both_y0", y0(), 431);
            chk("both_mov", 32'(pif.moving[0]), 0);
        end
        pif.btn_up[0] = 1'b1;
        settle();
        repeat (2) do_tick();
        pif.btn_up[0] = 1'b0;
        settle();
        do_tick();
        chk("glitch_y0", y0(), 431);
        pif.btn_down[0] = 1'b1;
        settle();
        repeat (3) begin
            do_tick();
            chk("down_release_y0", y0(), 431);
        end
        do_tick();
        chk("up_after_glitch_y0", y0(), 427);
        chk("up_after_glitch_lim", 32'(pif.at_limit[0]), 0);
        do_tick();
        chk("up_second_y0", y0(), 423);

        // Recentre wins over a simultaneous tick; held button keeps its debounce state.
        @(negedge clk);
        pif.tick     = 1'b1;
        pif.recenter = 1'b1;
        @(negedge clk);
        pif.tick     = 1'b0;
        pif.recenter = 1'b0;
        chk("recenter_y0", y0(), 217);
        chk("recenter_y1", y1(), 217);
        chk("recenter_mov", 32'(pif.moving), 0);
        do_tick();
        chk("resume_y0", y0(), 213);
        chk("resume_mov", 32'(pif.moving[0]), 1);

        // Channel 1 AI toward ball at 400: +3 per tick until within deadband.
        pif.mode   = 2'b10;
        pif.ball_y = 10'd400;
        do_tick();
        chk("ai_first_y1", y1(), 220);
        chk("ai_first_mov", 32'(pif.moving[1]), 1);
        repeat (52) do_tick();
        chk("ai_arrive_y1", y1(), 376);
        do_tick();
        chk("ai_deadband_y1", y1(), 376);
        chk("ai_deadband_mov", 32'(pif.moving[1]), 0);
        pif.ball_y = 10'd398;
        do_tick();
        chk("ai_err2_y1", y1(), 376);
        pif.ball_y = 10'd401;
        do_tick();
        chk("ai_err5_y1", y1(), 379);
        chk("ai_err5_mov", 32'(pif.moving[1]), 1);
        do_tick();
        chk("ai_settle_y1", y1(), 379);

        // Ball at top: AI climbs and clamps at MIN_Y without wrapping.
        pif.ball_y = 10'd0;
        do_tick();
        chk("ai_climb_y1", y1(), 376);
        repeat (130) do_tick();
        chk("ai_top_y1", y1(), 3);
        chk("ai_top_lim", 32'(pif.at_limit[1]), 1);
        chk("ai_top_mov", 32'(pif.moving[1]), 0);
        chk("player_top_y0", y0(), 3);
        chk("player_top_lim", 32'(pif.at_limit[0]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
